// File: rtl/param_pattern_timer.sv
// Serial start-pattern detector followed by a serially loaded delay timer.
// Once the pattern is found, DLY_W delay bits are shifted in and counted as (delay+1)*TICKS cycles.
module param_pattern_timer #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int unsigned      DLY_W   = 4,
  parameter int unsigned      TICKS   = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic             ack,
  input  logic             cancel,
  output logic             counting,
  output logic             done,
  output logic [DLY_W-1:0] remaining
);

  localparam int unsigned   TW        = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int unsigned   BW        = (DLY_W > 1) ? $clog2(DLY_W) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DLY_W - 1);

  typedef enum logic [1:0] {StSearch, StShift, StCount, StDone} state_t;

  state_t           state;
  logic [PAT_W-1:0] hist;
  logic [DLY_W-1:0] dly;
  logic [BW-1:0]    bit_cnt;
  logic [TW-1:0]    tick;
  logic [DLY_W-1:0] units;
  logic [PAT_W-1:0] hist_next;
  logic [DLY_W-1:0] dly_next;

  // The comparison includes the bit being sampled on this edge.
  always_comb begin
    hist_next = PAT_W'({hist, data});
    dly_next  = DLY_W'({dly, data});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StSearch;
      hist     <= '0;
      dly      <= '0;
      bit_cnt  <= '0;
      tick     <= '0;
      units    <= '0;
      counting <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        StSearch: begin
          if (hist_next == PATTERN) begin
            state   <= StShift;
            hist    <= '0;
            dly     <= '0;
            bit_cnt <= '0;
          end else begin
            hist <= hist_next;
          end
        end
        StShift: begin
          if (cancel) begin
            state   <= StSearch;
            dly     <= '0;
            bit_cnt <= '0;
          end else if (bit_cnt == BIT_LAST) begin
            state    <= StCount;
            dly      <= dly_next;
            units    <= dly_next;
            tick     <= '0;
            counting <= 1'b1;
          end else begin
            dly     <= dly_next;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        StCount: begin
          // Cancel outranks completion, even on the final cycle.
          if (cancel) begin
            state    <= StSearch;
            counting <= 1'b0;
            tick     <= '0;
            units    <= '0;
            dly      <= '0;
            bit_cnt  <= '0;
          end else if (tick == TICK_LAST) begin
            tick <= '0;
            if (units == '0) begin
              state    <= StDone;
              counting <= 1'b0;
              done     <= 1'b1;
            end else begin
              units <= units - 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        StDone: begin
          if (ack) begin
            state <= StSearch;
            done  <= 1'b0;
            hist  <= '0;
          end
        end
        default: state <= StSearch;
      endcase
    end
  end

  // units is held at zero outside COUNT, so it drives remaining directly.
  assign remaining = units;

endmodule

// File: tb/tb_param_pattern_timer.sv
// Drives three differently parameterised timers from one stimulus stream and checks each
// against an arithmetic reference model (elapsed-cycle count rather than tick/unit counters).
module tb_param_pattern_timer;

  localparam int M_SEARCH = 0;
  localparam int M_SHIFT  = 1;
  localparam int M_COUNT  = 2;
  localparam int M_DONE   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data = 1'b0;
  logic ack = 1'b0;
  logic cancel = 1'b0;

  logic       cnt0, cnt1, cnt2;
  logic       dn0, dn1, dn2;
  logic [3:0] rem0, rem1;
  logic [2:0] rem2;

  int checks = 0;
  int failures = 0;

  int unsigned p_patw[3]  = '{4, 4, 6};
  int unsigned p_pat[3]   = '{13, 13, 44};
  int unsigned p_dlyw[3]  = '{4, 4, 3};
  int unsigned p_ticks[3] = '{1000, 10, 3};

  int          m_mode[3];
  int unsigned m_hist[3];
  int unsigned m_dly[3];
  int unsigned m_nb[3];
  int unsigned m_el[3];

  always #5 clk = ~clk;

  param_pattern_timer u_def (
    .clk(clk), .reset(reset), .data(data), .ack(ack), .cancel(cancel),
    .counting(cnt0), .done(dn0), .remaining(rem0)
  );

  param_pattern_timer #(.PAT_W(4), .PATTERN(4'b1101), .DLY_W(4), .TICKS(10)) u_fast (
    .clk(clk), .reset(reset), .data(data), .ack(ack), .cancel(cancel),
    .counting(cnt1), .done(dn1), .remaining(rem1)
  );

  param_pattern_timer #(.PAT_W(6), .PATTERN(6'b101100), .DLY_W(3), .TICKS(3)) u_wide (
    .clk(clk), .reset(reset), .data(data), .ack(ack), .cancel(cancel),
    .counting(cnt2), .done(dn2), .remaining(rem2)
  );

  task automatic chk(input string tag, input int inst, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, inst, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = M_SEARCH;
      m_hist[i] = 0;
      m_dly[i]  = 0;
      m_nb[i]   = 0;
      m_el[i]   = 0;
    end
  endtask

  task automatic model_step(input logic d, input logic a, input logic c);
    for (int i = 0; i < 3; i++) begin
      int unsigned mask;
      int unsigned h;
      mask = (32'd1 << p_patw[i]) - 1;
      case (m_mode[i])
        M_SEARCH: begin
          h = ((m_hist[i] << 1) | 32'(d)) & mask;
          if (h == p_pat[i]) begin
            m_mode[i] = M_SHIFT;
            m_hist[i] = 0;
            m_dly[i]  = 0;
            m_nb[i]   = 0;
          end else begin
            m_hist[i] = h;
          end
        end
        M_SHIFT: begin
          if (c) begin
            m_mode[i] = M_SEARCH;
          end else begin
            m_dly[i] = (m_dly[i] << 1) | 32'(d);
            m_nb[i]++;
            if (m_nb[i] == p_dlyw[i]) begin
              m_mode[i] = M_COUNT;
              m_el[i]   = 0;
            end
          end
        end
        M_COUNT: begin
          if (c) begin
            m_mode[i] = M_SEARCH;
          end else begin
            m_el[i]++;
            if (m_el[i] == (m_dly[i] + 1) * p_ticks[i]) m_mode[i] = M_DONE;
          end
        end
        default: begin
          if (a) begin
            m_mode[i] = M_SEARCH;
            m_hist[i] = 0;
          end
        end
      endcase
    end
  endtask

  function automatic logic [31:0] obs_rem(input int i);
    case (i)
      0:       return 32'(rem0);
      1:       return 32'(rem1);
      default: return 32'(rem2);
    endcase
  endfunction

  function automatic logic [31:0] obs_cnt(input int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  function automatic logic [31:0] obs_done(input int i);
    case (i)
      0:       return 32'(dn0);
      1:       return 32'(dn1);
      default: return 32'(dn2);
    endcase
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int unsigned exp_rem;
      exp_rem = (m_mode[i] == M_COUNT) ? m_dly[i] - m_el[i] / p_ticks[i] : 0;
      chk("counting", i, obs_cnt(i), 32'(m_mode[i] == M_COUNT));
      chk("done", i, obs_done(i), 32'(m_mode[i] == M_DONE));
      chk("remaining", i, obs_rem(i), exp_rem);
    end
  endtask

  task automatic step(input logic d, input logic a = 1'b0, input logic c = 1'b0);
    data   = d;
    ack    = a;
    cancel = c;
    @(posedge clk);
    model_step(d, a, c);
    #1;
    check_all();
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    logic [15:0] b;
    b = v;
    for (int k = n - 1; k >= 0; k--) step(b[k]);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  initial begin
    bit found;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all();
    #2 reset = 1'b0;

    // Defaults: 1101 then delay 0001 -> 2000 counting cycles.
    send_bits(16'b1101_0001, 8);
    chk("t028_counting_rise", 0, 32'(cnt0), 1);
    chk("t028_remaining", 0, 32'(rem0), 1);
    chk("t033_no_1101", 2, 32'(cnt2), 0);
    idle(2000);
    chk("t028_done", 0, 32'(dn0), 1);
    chk("t028_counting_fall", 0, 32'(cnt0), 0);
    step(1'b0, 1'b1);
    chk("t028_ack", 0, 32'(dn0), 0);

    // Delay 0000: TICKS cycles with remaining 0.
    send_bits(16'b1101_0000, 8);
    idle(10);
    chk("t029_zero_done", 1, 32'(dn1), 1);
    idle(990);
    chk("t029_zero_def_done", 0, 32'(dn0), 1);
    step(1'b0, 1'b1);

    // Delay 1111: 160 cycles on the TICKS=10 instance.
    send_bits(16'b1101_1111, 8);
    chk("t029_max_rem", 1, 32'(rem1), 15);
    idle(160);
    chk("t029_max_done", 1, 32'(dn1), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("t024_cancel_in_done", 1, 32'(dn1), 1);
    step(1'b0, 1'b1, 1'b1);
    chk("t024_ack_cancel", 1, 32'(dn1), 0);

    // Overlapping match, delay 0010.
    send_bits(16'b1_1101_0010, 9);
    chk("t030_rem", 1, 32'(rem1), 2);
    idle(30);
    chk("t030_done", 1, 32'(dn1), 1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Cancel during SHIFT, then ack while searching.
    send_bits(16'b1101_01, 6);
    step(1'b0, 1'b0, 1'b1);
    idle(5);
    step(1'b0, 1'b1);
    chk("t031_shift_cancel", 1, 32'(cnt1), 0);

    // Cancel on the last COUNT cycle of the TICKS=10 instance.
    send_bits(16'b1101_0001, 8);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      if (m_mode[1] == M_COUNT && m_el[1] == (m_dly[1] + 1) * 10 - 1) found = 1'b1;
      else step(1'b0);
    end
    chk("t031_last_wait", 1, 32'(found), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("t031_last_cancel", 1, 32'(dn1), 0);
    idle(5);

    // Asynchronous reset in the middle of COUNT.
    send_bits(16'b1101_0011, 8);
    idle(15);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #3 reset = 1'b0;

    // Wide-pattern instance: 101100 then delay 101.
    send_bits(16'b101100_101, 9);
    chk("t033_counting", 2, 32'(cnt2), 1);
    chk("t033_rem", 2, 32'(rem2), 5);
    idle(18);
    chk("t033_done", 2, 32'(dn2), 1);
    step(1'b0, 1'b1);

    // Fresh run after reset.
    send_bits(16'b1101_0001, 8);
    idle(20);
    chk("t032_fresh_done", 1, 32'(dn1), 1);
    step(1'b0, 1'b1);

    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
